// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the alu_sequencer control slice: opcodes, FSM states,
// instruction field layout and the decode flag bundle.
package alu_sequencer_pkg;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 8;
  localparam int RS_MSB = 7;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 0;

  localparam logic [3:0] OP_JMP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_MOV = 4'hA;
  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_BNE = 4'hC;
  localparam logic [3:0] OP_BLT = 4'hD;
  localparam logic [3:0] OP_BGT = 4'hE;
  localparam logic [3:0] OP_CMP = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EX1,
    S_EX2,
    S_MEM,
    S_WB
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
  } instr_t;

  typedef struct packed {
    logic flag_en;
    logic is_branch;
    logic is_mem;
    logic is_store;
    logic writes_rd;
  } dec_t;

  function automatic instr_t unpack_instr(input logic [15:0] w);
    instr_t i;
    i.op = w[OP_MSB:OP_LSB];
    i.rd = w[RD_MSB:RD_LSB];
    i.rs = w[RS_MSB:RS_LSB];
    i.rt = w[RT_MSB:RT_LSB];
    return i;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction-fetch and data-memory req/ack buses of the sequencer.
// Requests are held until the matching ack is sampled high.
interface alu_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/alu_sequencer_seq_decode.sv
// Opcode classifier for the sequencer; purely combinational, zero latency,
// no flow control.
module seq_decode
  import alu_sequencer_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_XOR: begin
        dec.flag_en   = 1'b1;
        dec.writes_rd = 1'b1;
      end
      OP_LD: begin
        dec.is_mem    = 1'b1;
        dec.writes_rd = 1'b1;
      end
      OP_ST: begin
        dec.is_mem   = 1'b1;
        dec.is_store = 1'b1;
      end
      OP_MOV:                                 dec.writes_rd = 1'b1;
      OP_JMP, OP_BEQ, OP_BNE, OP_BLT, OP_BGT: dec.is_branch = 1'b1;
      OP_CMP:                                 dec.flag_en   = 1'b1;
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer; 5 cycles per ALU op, 4 per branch/CMP,
// memory ops add the dmem wait; imem/dmem requests stall the FSM until acked.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  alu_sequencer_if.master   bus,
  output logic [3:0]        rf_raddr0,
  output logic [3:0]        rf_raddr1,
  input  logic [DATA_W-1:0] rf_rdata1,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        alu_func,
  output logic              alu_flag_en,
  input  logic [DATA_W-1:0] alu_q,
  input  logic              alu_b_out,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] retired,
  output logic              busy
);

  state_t            state;
  instr_t            instr_q;
  dec_t              dec;
  logic              imem_req_q;
  logic              dmem_req_q;
  logic              dmem_we_q;
  logic [DATA_W-1:0] dmem_addr_q;
  logic [DATA_W-1:0] dmem_wdata_q;
  instr_t            fetched;

  seq_decode u_seq_decode (
    .op  (instr_q.op),
    .dec (dec)
  );

  assign fetched        = unpack_instr(bus.imem_rdata);
  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign busy           = (state != S_FETCH) || imem_req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      instr_q      <= '0;
      pc           <= RESET_PC;
      retired      <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      rf_raddr0    <= '0;
      rf_raddr1    <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      alu_func     <= '0;
      alu_flag_en  <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      unique case (state)
        S_FETCH: begin
          if (imem_req_q) begin
            if (bus.imem_ack) begin
              instr_q    <= fetched;
              rf_raddr0  <= fetched.rs;
              rf_raddr1  <= fetched.rt;
              pc         <= pc + 1'b1;
              imem_req_q <= 1'b0;
              state      <= S_DECODE;
            end
          end else if (run) begin
            imem_req_q <= 1'b1;
          end
        end

        S_DECODE: begin
          alu_func    <= instr_q.op;
          alu_flag_en <= dec.flag_en;
          state       <= S_EX1;
        end

        // Func is dropped as soon as the ALU has latched it so flags cannot
        // be touched again outside the sequencer's execute window.
        S_EX1: begin
          alu_func    <= '0;
          alu_flag_en <= 1'b0;
          state       <= S_EX2;
        end

        S_EX2: begin
          if (dec.is_mem) begin
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= dec.is_store;
            dmem_addr_q  <= alu_q;
            dmem_wdata_q <= dec.is_store ? rf_rdata1 : '0;
            state        <= S_MEM;
          end else if (dec.writes_rd) begin
            rf_we    <= 1'b1;
            rf_waddr <= instr_q.rd;
            rf_wdata <= alu_q;
            state    <= S_WB;
          end else begin
            if (dec.is_branch && alu_b_out) begin
              pc <= alu_q;
            end
            retired    <= retired + 1'b1;
            imem_req_q <= run;
            state      <= S_FETCH;
          end
        end

        S_MEM: begin
          if (bus.dmem_ack) begin
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            if (dec.is_store) begin
              retired    <= retired + 1'b1;
              imem_req_q <= run;
              state      <= S_FETCH;
            end else begin
              rf_we    <= 1'b1;
              rf_waddr <= instr_q.rd;
              rf_wdata <= bus.dmem_rdata;
              state    <= S_WB;
            end
          end
        end

        S_WB: begin
          retired    <= retired + 1'b1;
          imem_req_q <= run;
          state      <= S_FETCH;
        end

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized bench for alu_sequencer against an instruction-level model.
module tb_alu_sequencer;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [3:0]  rf_raddr0, rf_raddr1, rf_waddr, alu_func;
  logic [15:0] rf_rdata1, rf_wdata, alu_q, pc, retired;
  logic        rf_we, alu_flag_en, alu_b_out, busy;

  logic [15:0] regs [16];
  logic [15:0] m_pc;
  logic [15:0] m_ret;
  int          tests = 0;
  int          fails = 0;

  alu_sequencer_if bus ();

  alu_sequencer #(.RESET_PC(RST_PC), .DATA_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .bus         (bus),
    .rf_raddr0   (rf_raddr0),
    .rf_raddr1   (rf_raddr1),
    .rf_rdata1   (rf_rdata1),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .alu_func    (alu_func),
    .alu_flag_en (alu_flag_en),
    .alu_q       (alu_q),
    .alu_b_out   (alu_b_out),
    .pc          (pc),
    .retired     (retired),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  assign rf_rdata1 = regs[rf_raddr1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plays imem, dmem and ALU for one instruction and checks it against the
  // instruction-level effects (pc, retire count, rf write, memory transfer, timing).
  task automatic exec(input logic [15:0] ins, input logic [15:0] qv, input logic bv,
                      input int flen, input int mlen, input logic [15:0] ldv,
                      input bit run_after, input bit abort_mem);
    logic [3:0]  op, rd, rs, rt;
    bit          alu_wr, br, mem, st, cmp, fl, wr;
    logic [15:0] exp_pc, exp_wdata, exp_ret;
    int          exp_lat, cyc, ack_cyc, k, lat, freq, mreq, we_cnt;
    bit          done, leak, overlap, busy_bad;
    logic        m_we;
    logic [15:0] m_addr, m_wdata, w_data;
    logic [3:0]  w_addr;

    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    alu_wr = (op >= 4'd1 && op <= 4'd7) || op == 4'hA;
    mem    = (op == 4'h8) || (op == 4'h9);
    st     = (op == 4'h9);
    cmp    = (op == 4'hF);
    br     = !alu_wr && !mem && !cmp;
    fl     = (op >= 4'd1 && op <= 4'd7) || cmp;
    wr     = alu_wr || op == 4'h8;
    exp_pc    = (br && bv) ? qv : m_pc + 16'd1;
    exp_ret   = m_ret + 16'd1;
    exp_wdata = (op == 4'h8) ? ldv : qv;
    if (alu_wr)          exp_lat = 5;
    else if (br || cmp)  exp_lat = 4;
    else if (st)         exp_lat = 4 + mlen;
    else                 exp_lat = 5 + mlen;

    cyc = 0; ack_cyc = -1; lat = -1; freq = 0; mreq = 0; we_cnt = 0;
    done = 0; leak = 0; overlap = 0; busy_bad = 0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; w_addr = '0; w_data = '0;

    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 16'($urandom);
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = 16'($urandom);
      alu_q          = 16'($urandom);
      alu_b_out      = 1'($urandom);
      if (rf_we && bus.dmem_req) overlap = 1;
      if (ack_cyc < 0) begin
        if (bus.imem_req) begin
          freq++;
          if (freq == flen) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = ins;
            ack_cyc        = cyc;
            chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
            if (!run_after) run = 1'b0;
          end
        end
      end else if (retired !== m_ret) begin
        done = 1;
        lat  = cyc - ack_cyc;
      end else begin
        k = cyc - ack_cyc;
        if (!busy) busy_bad = 1;
        if (k == 2) begin
          chk("ex1_func", 32'(alu_func), 32'(op));
          chk("ex1_flag_en", 32'(alu_flag_en), 32'(fl));
          chk("ex1_raddr0", 32'(rf_raddr0), 32'(rs));
          chk("ex1_raddr1", 32'(rf_raddr1), 32'(rt));
        end else if (k != 3 && (alu_func != 4'd0 || alu_flag_en)) begin
          leak = 1;
        end
        if (k == 3) begin
          alu_q     = qv;
          alu_b_out = bv;
        end
        if (bus.dmem_req) begin
          mreq++;
          if (mreq == 1) begin
            m_we = bus.dmem_we; m_addr = bus.dmem_addr; m_wdata = bus.dmem_wdata;
          end
          if (abort_mem && mreq == 2) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_dmem_req", 32'(bus.dmem_req), 0);
            chk("rst_pc", 32'(pc), 32'(RST_PC));
            chk("rst_retired", 32'(retired), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rf_we", 32'(rf_we), 0);
            m_pc  = RST_PC;
            m_ret = '0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
          end
          if (mreq == mlen) begin
            bus.dmem_ack   = 1'b1;
            bus.dmem_rdata = ldv;
          end
        end
        if (rf_we) begin
          we_cnt++;
          w_addr = rf_waddr;
          w_data = rf_wdata;
        end
      end
    end

    chk("completed", 32'(done), 1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("pc", 32'(pc), 32'(exp_pc));
    chk("retired", 32'(retired), 32'(exp_ret));
    chk("rf_we_count", 32'(we_cnt), wr ? 1 : 0);
    if (wr) begin
      chk("rf_waddr", 32'(w_addr), 32'(rd));
      chk("rf_wdata", 32'(w_data), 32'(exp_wdata));
    end
    chk("dmem_req_cycles", 32'(mreq), mem ? 32'(mlen) : 0);
    if (mem) begin
      chk("dmem_we", 32'(m_we), 32'(st));
      chk("dmem_addr", 32'(m_addr), 32'(qv));
      if (st) chk("dmem_wdata", 32'(m_wdata), 32'(regs[rt]));
    end
    chk("func_outside_ex", 32'(leak), 0);
    chk("we_req_overlap", 32'(overlap), 0);
    chk("busy_in_flight", 32'(busy_bad), 0);

    m_pc  = exp_pc;
    m_ret = exp_ret;
    if (wr) regs[rd] = exp_wdata;

    if (!run_after) begin
      repeat (3) begin
        @(negedge clk);
        chk("idle_imem_req", 32'(bus.imem_req), 0);
        chk("idle_busy", 32'(busy), 0);
      end
      run = 1'b1;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    run            = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    alu_q          = '0;
    alu_b_out      = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    m_pc  = RST_PC;
    m_ret = '0;

    repeat (2) @(negedge clk);
    chk("reset_pc", 32'(pc), 32'(RST_PC));
    chk("reset_imem_addr", 32'(bus.imem_addr), 32'(RST_PC));
    chk("reset_retired", 32'(retired), 0);
    chk("reset_imem_req", 32'(bus.imem_req), 0);
    chk("reset_dmem_req", 32'(bus.dmem_req), 0);
    chk("reset_dmem_we", 32'(bus.dmem_we), 0);
    chk("reset_dmem_addr", 32'(bus.dmem_addr), 0);
    chk("reset_dmem_wdata", 32'(bus.dmem_wdata), 0);
    chk("reset_rf_we", 32'(rf_we), 0);
    chk("reset_rf_waddr", 32'(rf_waddr), 0);
    chk("reset_rf_wdata", 32'(rf_wdata), 0);
    chk("reset_raddr", 32'({rf_raddr0, rf_raddr1}), 0);
    chk("reset_alu_func", 32'(alu_func), 0);
    chk("reset_flag_en", 32'(alu_flag_en), 0);
    chk("reset_busy", 32'(busy), 0);

    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("run0_imem_req", 32'(bus.imem_req), 0);
    chk("run0_busy", 32'(busy), 0);
    run = 1'b1;

    // ADD R1 = R2 + R3, then a taken BEQ, a slow LD and a ST
    exec(16'h1123, 16'h0005, 1'b0, 1, 1, 16'h0000, 1'b1, 1'b0);
    exec(16'hB004, 16'h0040, 1'b1, 1, 1, 16'h0000, 1'b1, 1'b0);
    exec(16'h8312, 16'h0300, 1'b0, 2, 3, 16'hBEEF, 1'b1, 1'b0);
    regs[6] = 16'h1234;
    exec(16'h9056, 16'h0100, 1'b1, 1, 1, 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      exec(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(1, 3)),
           int'($urandom_range(1, 4)), 16'($urandom), 1'b1, 1'b0);
    end

    // Jump to the top of memory, fetch there with run dropping after the ack
    exec(16'h000F, 16'hFFFF, 1'b1, 1, 1, 16'h0000, 1'b1, 1'b0);
    exec(16'hA412, 16'h7777, 1'b1, 1, 1, 16'h0000, 1'b0, 1'b0);
    chk("pc_wrapped", 32'(pc), 0);

    exec(16'h8745, 16'h0200, 1'b0, 1, 5, 16'h1111, 1'b1, 1'b1);
    exec(16'h2567, 16'h0ABC, 1'b0, 1, 1, 16'h0000, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
